// File: rtl/text_overlay_pkg.sv
// Shared constants, pipeline types and font-ROM helpers for the text overlay.
package text_overlay_pkg;
    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;
    localparam int ROM_AW = 14;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } sync_t;

    // Column-major glyph storage: one 16-bit column word per (glyph, col).
    function automatic logic [ROM_AW-1:0] font_addr(input logic [7:0] ascii,
                                                    input logic [2:0] col,
                                                    input logic [3:0] row);
        return {ascii[6:0], col, row};
    endfunction

    function automatic logic is_printable(input logic [7:0] code);
        return (code >= 8'h20) && (code <= 8'h7E);
    endfunction
endpackage

// File: rtl/text_overlay_buf.sv
// Staging and active text/origin; staging is copied to active on the vs rising
// edge so a frame never shows a half-written string.
module text_overlay_buf
    import text_overlay_pkg::*;
#(
    parameter int N_CHARS = 16,
    parameter int CW = 12
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [$clog2(N_CHARS)-1:0]   wr_idx,
    input  logic [7:0]                   wr_char,
    input  logic [CW-1:0]                org_x,
    input  logic [CW-1:0]                org_y,
    input  logic                         vs_in,
    output logic [N_CHARS-1:0][7:0]      act_text,
    output logic [CW-1:0]                act_x,
    output logic [CW-1:0]                act_y
);
    logic [N_CHARS-1:0][7:0] stg_q, stg_d, act_q, act_d;
    logic [CW-1:0] stg_x_q, stg_x_d, stg_y_q, stg_y_d;
    logic [CW-1:0] act_x_q, act_x_d, act_y_q, act_y_d;
    logic vs_prev_q;
    logic commit;

    assign commit = vs_in & ~vs_prev_q;

    // Commit copies the pre-write staging contents; a same-cycle write waits a frame.
    always_comb begin
        stg_d   = stg_q;
        stg_x_d = stg_x_q;
        stg_y_d = stg_y_q;
        if (wr_en) begin
            stg_d[wr_idx] = wr_char;
            stg_x_d       = org_x;
            stg_y_d       = org_y;
        end
        act_d   = act_q;
        act_x_d = act_x_q;
        act_y_d = act_y_q;
        if (commit) begin
            act_d   = stg_q;
            act_x_d = stg_x_q;
            act_y_d = stg_y_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg_q     <= {N_CHARS{ASCII_SPACE}};
            act_q     <= {N_CHARS{ASCII_SPACE}};
            stg_x_q   <= '0;
            stg_y_q   <= '0;
            act_x_q   <= '0;
            act_y_q   <= '0;
            vs_prev_q <= 1'b0;
        end else begin
            stg_q     <= stg_d;
            act_q     <= act_d;
            stg_x_q   <= stg_x_d;
            stg_y_q   <= stg_y_d;
            act_x_q   <= act_x_d;
            act_y_q   <= act_y_d;
            vs_prev_q <= vs_in;
        end
    end

    assign act_text = act_q;
    assign act_x    = act_x_q;
    assign act_y    = act_y_q;
endmodule

// File: rtl/text_overlay_render.sv
// Text overlay: window hit test, font ROM addressing and a 2-stage pipeline
// that re-aligns sync/background with the registered ROM pixel.
module text_overlay_render
    import text_overlay_pkg::*;
#(
    parameter int N_CHARS = 16,
    parameter int CW = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(N_CHARS)-1:0] wr_idx,
    input  logic [7:0]                 wr_char,
    input  logic [CW-1:0]              org_x,
    input  logic [CW-1:0]              org_y,
    input  logic [23:0]                fg_rgb,
    input  logic                       de_in,
    input  logic                       hs_in,
    input  logic                       vs_in,
    input  logic [CW-1:0]              x_in,
    input  logic [CW-1:0]              y_in,
    input  logic [23:0]                rgb_in,
    output logic [ROM_AW-1:0]          rom_ad,
    output logic                       rom_ce,
    output logic                       rom_oce,
    input  logic                       rom_dout,
    output logic                       de_out,
    output logic                       hs_out,
    output logic                       vs_out,
    output logic [23:0]                rgb_out
);
    localparam int IW = $clog2(N_CHARS);
    localparam logic [CW:0] WIN_W = (CW+1)'(GLYPH_W * N_CHARS);
    localparam logic [CW:0] WIN_H = (CW+1)'(GLYPH_H);

    logic [N_CHARS-1:0][7:0] act_text;
    logic [CW-1:0] act_x, act_y;

    text_overlay_buf #(.N_CHARS(N_CHARS), .CW(CW)) u_buf (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_char  (wr_char),
        .org_x    (org_x),
        .org_y    (org_y),
        .vs_in    (vs_in),
        .act_text (act_text),
        .act_x    (act_x),
        .act_y    (act_y)
    );

    logic [CW:0] dx, dy;
    logic        in_win, hit;
    logic [7:0]  cur_char;

    // One extra bit so a pixel left of / above the origin cannot wrap into range.
    assign dx = {1'b0, x_in} - {1'b0, act_x};
    assign dy = {1'b0, y_in} - {1'b0, act_y};
    assign in_win = de_in && (x_in >= act_x) && (dx < WIN_W)
                          && (y_in >= act_y) && (dy < WIN_H);
    assign cur_char = act_text[dx[IW+2:3]];
    assign hit = in_win && is_printable(cur_char);

    assign rom_ad  = in_win ? font_addr(cur_char, dx[2:0], dy[3:0])
                            : font_addr(ASCII_SPACE, 3'd0, 4'd0);
    assign rom_ce  = 1'b1;
    assign rom_oce = 1'b1;

    sync_t       sync1_q, sync2_q;
    logic        hit1_q;
    logic [23:0] rgb1_q, rgb2_q, rgb2_d;

    // rom_dout lines up with stage 1, so the mux happens on the way into stage 2.
    assign rgb2_d = (hit1_q && rom_dout) ? fg_rgb : rgb1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            hit1_q  <= 1'b0;
            rgb1_q  <= '0;
            rgb2_q  <= '0;
        end else begin
            sync1_q <= '{de: de_in, hs: hs_in, vs: vs_in};
            sync2_q <= sync1_q;
            hit1_q  <= hit;
            rgb1_q  <= rgb_in;
            rgb2_q  <= rgb2_d;
        end
    end

    assign de_out  = sync2_q.de;
    assign hs_out  = sync2_q.hs;
    assign vs_out  = sync2_q.vs;
    assign rgb_out = rgb2_q;
endmodule
